// File: rtl/rsi_pkg.sv
// ============================================================
// rsi_pkg : shared constants and state encoding for rsi_calc
// Rev 1.0
// ============================================================
`default_nettype none

package rsi_pkg;

    localparam int RSI_DW      = 32;
    localparam int RSI_WINDOW  = 14;
    localparam int RSI_SCALE   = 100;
    localparam int RSI_NEUTRAL = 50;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DIV   = 2'd3
    } rsi_state_e;

endpackage

`default_nettype wire

// File: rtl/rsi_div.sv
// ============================================================
// rsi_div : 7-bit restoring divider, one quotient bit per cycle
// Rev 1.0
// ============================================================
`default_nettype none

module rsi_div #(
    parameter int NW   = 44,
    parameter int DENW = 38
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NW-1:0]   num,
    input  logic [DENW-1:0] den,
    output logic            done,
    output logic [6:0]      quot
);

    logic [NW-1:0]   rem_q,  rem_d;
    logic [DENW-1:0] den_q,  den_d;
    logic [6:0]      quot_q, quot_d;
    logic [2:0]      bit_q,  bit_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [NW-1:0]   w_rem;
    logic [NW-1:0]   w_shift;
    logic [DENW-1:0] w_den;
    logic [2:0]      w_bit;

    // The start cycle resolves bit 6 straight from the operand inputs
    always_comb begin
        rem_d   = rem_q;
        den_d   = den_q;
        quot_d  = quot_q;
        bit_d   = bit_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        w_rem   = start ? num : rem_q;
        w_den   = start ? den : den_q;
        w_bit   = start ? 3'd6 : bit_q;
        w_shift = NW'(w_den) << w_bit;

        if (start || busy_q) begin
            den_d = w_den;
            if (start) begin
                quot_d = 7'd0;
            end
            if (w_rem >= w_shift) begin
                rem_d         = w_rem - w_shift;
                quot_d[w_bit] = 1'b1;
            end else begin
                rem_d         = w_rem;
                quot_d[w_bit] = 1'b0;
            end
            if (w_bit == 3'd0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
                bit_d  = w_bit - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            quot_q <= '0;
            bit_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            quot_q <= quot_d;
            bit_q  <= bit_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign quot = quot_q;

endmodule

`default_nettype wire

// File: rtl/rsi_calc.sv
// ============================================================
// rsi_calc : sliding-window RSI over WINDOW price deltas
// Rev 1.0
// ============================================================
`default_nettype none

module rsi_calc
    import rsi_pkg::*;
#(
    parameter int WINDOW = RSI_WINDOW,
    parameter int DW     = RSI_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] price,
    input  logic          price_valid,
    output logic          price_ready,
    output logic [DW-1:0] RSI,
    output logic          rsi_valid
);

    localparam int SW   = DW + 5;
    localparam int NW   = SW + 7;
    localparam int DENW = SW + 1;
    localparam int PW   = $clog2(WINDOW);
    localparam int CW   = $clog2(WINDOW + 1);

    rsi_state_e      state_q,     state_d;
    logic [DW-1:0]   prev_q,      prev_d;
    logic [DW-1:0]   gain_new_q,  gain_new_d;
    logic [DW-1:0]   loss_new_q,  loss_new_d;
    logic [DW-1:0]   gain_old_q,  gain_old_d;
    logic [DW-1:0]   loss_old_q,  loss_old_d;
    logic            upd_q,       upd_d;
    logic [SW-1:0]   g_sum_q,     g_sum_d;
    logic [SW-1:0]   l_sum_q,     l_sum_d;
    logic [PW-1:0]   ptr_q,       ptr_d;
    logic [CW-1:0]   fill_q,      fill_d;
    logic [3:0]      cnt_q,       cnt_d;
    logic [DW-1:0]   rsi_q,       rsi_d;
    logic            rsi_valid_q, rsi_valid_d;

    logic [DW-1:0]   gain_buf_q [WINDOW];
    logic [DW-1:0]   loss_buf_q [WINDOW];

    logic            w_accept;
    logic            w_full;
    logic            w_buf_we;
    logic            w_div_start;
    logic            w_div_done;
    logic [6:0]      w_quot;
    logic [NW-1:0]   w_num;
    logic [DENW-1:0] w_den;

    assign price_ready = (state_q != DIV);
    assign w_accept    = price_valid && price_ready;
    assign w_full      = (fill_q == CW'(WINDOW));
    assign w_buf_we    = w_accept && (state_q == FILL || state_q == RUN);
    assign w_div_start = (state_q == DIV) && (cnt_q == 4'd1);
    assign w_num       = NW'(g_sum_q) * NW'(RSI_SCALE);
    assign w_den       = DENW'(g_sum_q) + DENW'(l_sum_q);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        gain_new_d  = gain_new_q;
        loss_new_d  = loss_new_q;
        gain_old_d  = gain_old_q;
        loss_old_d  = loss_old_q;
        upd_d       = 1'b0;
        g_sum_d     = g_sum_q;
        l_sum_d     = l_sum_q;
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        rsi_d       = rsi_q;
        rsi_valid_d = 1'b0;

        // Sums lag the delta capture by one edge; the evicted pair is zero while filling
        if (upd_q) begin
            g_sum_d = g_sum_q + SW'(gain_new_q) - SW'(gain_old_q);
            l_sum_d = l_sum_q + SW'(loss_new_q) - SW'(loss_old_q);
        end

        case (state_q)
            EMPTY: begin
                if (w_accept) begin
                    prev_d  = price;
                    state_d = FILL;
                end
            end
            FILL, RUN: begin
                if (w_accept) begin
                    prev_d     = price;
                    gain_new_d = (price > prev_q) ? price - prev_q : '0;
                    loss_new_d = (prev_q > price) ? prev_q - price : '0;
                    gain_old_d = w_full ? gain_buf_q[ptr_q] : '0;
                    loss_old_d = w_full ? loss_buf_q[ptr_q] : '0;
                    upd_d      = 1'b1;
                    ptr_d      = (ptr_q == PW'(WINDOW - 1)) ? '0 : ptr_q + 1'b1;
                    if (!w_full) begin
                        fill_d = fill_q + 1'b1;
                    end
                    if (w_full || fill_q == CW'(WINDOW - 1)) begin
                        state_d = DIV;
                        cnt_d   = 4'd0;
                    end
                end
            end
            DIV: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    state_d = RUN;
                end
            end
            default: state_d = EMPTY;
        endcase

        if (w_div_done) begin
            rsi_d       = (w_den == '0) ? DW'(RSI_NEUTRAL) : DW'(w_quot);
            rsi_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            prev_q      <= '0;
            gain_new_q  <= '0;
            loss_new_q  <= '0;
            gain_old_q  <= '0;
            loss_old_q  <= '0;
            upd_q       <= 1'b0;
            g_sum_q     <= '0;
            l_sum_q     <= '0;
            ptr_q       <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            rsi_q       <= '0;
            rsi_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            gain_new_q  <= gain_new_d;
            loss_new_q  <= loss_new_d;
            gain_old_q  <= gain_old_d;
            loss_old_q  <= loss_old_d;
            upd_q       <= upd_d;
            g_sum_q     <= g_sum_d;
            l_sum_q     <= l_sum_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            rsi_q       <= rsi_d;
            rsi_valid_q <= rsi_valid_d;
        end
    end

    // Delta history needs no reset: entries are only read once the fill count says they are valid
    always_ff @(posedge clk) begin
        if (w_buf_we) begin
            gain_buf_q[ptr_q] <= gain_new_d;
            loss_buf_q[ptr_q] <= loss_new_d;
        end
    end

    rsi_div #(
        .NW   (NW),
        .DENW (DENW)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_div_start),
        .num   (w_num),
        .den   (w_den),
        .done  (w_div_done),
        .quot  (w_quot)
    );

    assign RSI       = rsi_q;
    assign rsi_valid = rsi_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rsi_calc.sv
// ============================================================
// tb_rsi_calc : directed stimulus against a sliding-window RSI model
// Rev 1.0
// ============================================================
`default_nettype none

module tb_rsi_calc;

    localparam int WIN = 4;
    localparam int DWT = 32;

    logic            clk;
    logic            rst_n;
    logic [DWT-1:0]  price;
    logic            price_valid;
    logic            price_ready;
    logic [DWT-1:0]  RSI;
    logic            rsi_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint due;
        longint val;
    } exp_t;

    longint hist[$];
    exp_t   expq[$];
    longint ncyc      = 0;
    longint low_until = -1;
    longint held      = 0;
    int     pulses    = 0;

    rsi_calc #(
        .WINDOW (WIN),
        .DW     (DWT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .price       (price),
        .price_valid (price_valid),
        .price_ready (price_ready),
        .RSI         (RSI),
        .rsi_valid   (rsi_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sum of gains (or losses) over the last WIN deltas of the accepted-price history
    function automatic longint model_sum(input bit gains);
        longint s = 0;
        int n = hist.size();
        for (int i = n - WIN; i < n; i++) begin
            longint d = hist[i] - hist[i-1];
            if (gains && d > 0) s += d;
            if (!gains && d < 0) s -= d;
        end
        return s;
    endfunction

    function automatic longint model_rsi();
        longint g = model_sum(1'b1);
        longint l = model_sum(1'b0);
        return (g + l == 0) ? 50 : (100 * g) / (g + l);
    endfunction

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            hist.delete();
            expq.delete();
            low_until = -1;
            held      = 0;
            chk("rst_ready", longint'(price_ready), 1);
            chk("rst_rsi",   longint'(RSI), 0);
            chk("rst_valid", longint'(rsi_valid), 0);
        end else begin
            bit exp_v;
            chk("ready", longint'(price_ready), longint'(ncyc > low_until));
            exp_v = (expq.size() > 0) && (expq[0].due == ncyc);
            chk("rsi_valid", longint'(rsi_valid), longint'(exp_v));
            if (expq.size() > 0 && expq[0].due <= ncyc) begin
                held = expq[0].val;
                void'(expq.pop_front());
            end
            chk("rsi", longint'(RSI), held);
            if (rsi_valid) pulses++;
            if (price_valid && (ncyc > low_until)) begin
                hist.push_back(longint'(price));
                if (hist.size() >= WIN + 1) begin
                    expq.push_back(exp_t'{due: ncyc + 10, val: model_rsi()});
                    low_until = ncyc + 10;
                end
            end
        end
    end

    task automatic do_reset();
        price_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Leaves price_valid high so consecutive calls model a continuously valid upstream
    task automatic send(input int p);
        int guard = 0;
        price       = DWT'(p);
        price_valid = 1'b1;
        @(negedge clk);
        while (!price_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        price_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int p0;
    int seq_up[5]    = '{10, 11, 12, 13, 14};
    int seq_down[5]  = '{10, 9, 8, 7, 6};
    int seq_mix[5]   = '{10, 13, 12, 13, 12};
    int seq_slide[9] = '{10, 12, 11, 15, 14, 14, 9, 20, 18};

    initial begin
        rst_n       = 1'b0;
        price       = '0;
        price_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_reset_rsi",   longint'(RSI), 0);
        chk("lit_reset_valid", longint'(rsi_valid), 0);
        chk("lit_reset_ready", longint'(price_ready), 1);
        #1 rst_n = 1'b1;

        // Rising prices
        p0 = pulses;
        foreach (seq_up[i]) send(seq_up[i]);
        idle(14);
        chk("lit_up_rsi",    longint'(RSI), 100);
        chk("lit_up_pulses", pulses - p0, 1);

        // Falling prices, then one uptick
        do_reset();
        foreach (seq_down[i]) send(seq_down[i]);
        idle(14);
        chk("lit_down_rsi", longint'(RSI), 0);
        send(7);
        idle(14);
        chk("lit_g1", model_sum(1'b1), 1);
        chk("lit_l3", model_sum(1'b0), 3);
        chk("lit_rsi25", longint'(RSI), 25);

        // Mixed deltas: floor rounding
        do_reset();
        foreach (seq_mix[i]) send(seq_mix[i]);
        idle(14);
        chk("lit_g4", model_sum(1'b1), 4);
        chk("lit_l2", model_sum(1'b0), 2);
        chk("lit_rsi66", longint'(RSI), 66);

        // Flat prices: neutral result
        do_reset();
        repeat (5) send(10);
        idle(14);
        chk("lit_rsi50", longint'(RSI), 50);

        // Reset in the middle of a division
        do_reset();
        p0 = pulses;
        foreach (seq_up[i]) send(seq_up[i]);
        idle(4);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_middiv_rsi",   longint'(RSI), 0);
        chk("lit_middiv_ready", longint'(price_ready), 1);
        rst_n = 1'b1;
        idle(12);
        chk("lit_middiv_nopulse", pulses - p0, 0);
        for (int i = 0; i < 4; i++) send(20 + i);
        idle(15);
        chk("lit_refill4_nopulse", pulses - p0, 0);
        send(30);
        idle(14);
        chk("lit_refill5_pulse", pulses - p0, 1);

        // Sliding window with continuous valid and pointer wrap
        do_reset();
        p0 = pulses;
        foreach (seq_slide[i]) send(seq_slide[i]);
        idle(14);
        chk("lit_slide_pulses", pulses - p0, 5);
        chk("lit_slide_rsi61",  longint'(RSI), 61);
        chk("lit_slide_queue",  longint'(expq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/rsi_calc.md
RSI_CALC -- requirements
Module: rsi_calc

Interface
REQ-001 SHALL provide parameter WINDOW, default 14, meaning the number of price deltas averaged; legal range 2..32.
REQ-002 SHALL provide parameter DW, default 32, meaning the price and RSI bus width.
REQ-003 SHALL provide port clk  input  1  the single clock; all state changes on rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port price  input  DW  unsigned price sample.
REQ-006 SHALL provide port price_valid  input  1  price is presented this cycle.
REQ-007 SHALL provide port price_ready  output  1  the block can accept a price this cycle.
REQ-008 SHALL provide port RSI  output  DW  RSI value 0..100, zero-extended, in the form consumed by the rsi threshold block.
REQ-009 SHALL provide port rsi_valid  output  1  one-cycle pulse marking a new RSI value.

Function
REQ-010 SHALL accept a price only on a rising edge where price_valid and price_ready are both high.
REQ-011 SHALL use states EMPTY (no previous price), FILL (fewer than WINDOW deltas), RUN (window full, idle), and DIV (computing).
REQ-012 SHALL, in EMPTY, store the accepted price as the previous price and go to FILL; no delta is recorded.
REQ-013 SHALL compute each delta from the accepted price and the previous price: gain = price-prev if price>prev, else 0; loss = prev-price if prev>price, else 0; equal prices give gain=loss=0.
REQ-014 SHALL keep the last WINDOW gain/loss pairs in a circular buffer; once the buffer is full, SHALL subtract the oldest pair from running sums G and L and add the newest.
REQ-015 SHALL hold G and L at DW+5 bits so that no overflow occurs at WINDOW=32.
REQ-016 SHALL move from FILL to DIV on the acceptance that records the WINDOW-th delta, and from RUN to DIV on every acceptance.
REQ-017 SHALL compute RSI = floor(100*G/(G+L)) with a restoring divider that produces 7 quotient bits, one bit per cycle.
REQ-018 SHALL output RSI = 50 when G+L = 0, with the same latency as a normal result.
REQ-019 SHALL use the following timing when a price is accepted at edge k:
  - G and L are updated at edge k+1.
  - Division runs from edge k+2 through edge k+8.
  - RSI and rsi_valid are registered at edge k+9.
  - Fixed latency is 9 cycles.
REQ-020 SHALL drive price_ready low from edge k through edge k+9, and high in EMPTY, FILL and RUN.
REQ-021 SHALL ignore price_valid while price_ready is low; the upstream holds its price until it is accepted.
REQ-022 SHALL hold RSI stable between rsi_valid pulses.
REQ-023 SHALL wrap the buffer write pointer from WINDOW-1 back to 0.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear the state to EMPTY and set RSI=0, rsi_valid=0, G=L=0, pointer=0, fill count=0, and previous price=0.
REQ-025 SHALL drive price_ready high during reset and from the first edge after reset release.
REQ-026 SHALL, on reset during DIV, abort the division with no rsi_valid pulse, and SHALL require a full refill before the next output.

Structure
REQ-027 SHALL place DW, the default WINDOW, RSI_SCALE=100, RSI_NEUTRAL=50 and the state enumeration in shared package rsi_pkg.
REQ-028 SHALL implement the divider as sub-module rsi_div, which has start/done handshaking, a 7-bit quotient, and takes numerator 100*G and denominator G+L.

Verification
REQ-029 SHALL cover, with WINDOW=4, prices 10,11,12,13,14 -> a single rsi_valid pulse 9 cycles after the 5th acceptance with RSI=100.
REQ-030 SHALL cover, with WINDOW=4, prices 10,9,8,7,6 -> RSI=0; then price 7 -> G=1, L=3, RSI=25.
REQ-031 SHALL cover, with WINDOW=4, prices 10,13,12,13,12 -> G=4, L=2, RSI=66 (floor); and prices 10,10,10,10,10 -> RSI=50.
REQ-032 SHALL cover, with price_valid held high continuously -> price_ready low for 10 cycles after each post-fill acceptance, no sample lost or duplicated, and one rsi_valid per acceptance.
REQ-033 SHALL cover rst_n asserted mid-DIV -> no rsi_valid pulse, RSI=0, and price_ready high; then 5 fresh prices are needed before the next rsi_valid.
REQ-034 SHALL cover, with WINDOW=4, a run of 9 prices -> the oldest delta evicted each step and the pointer wrapping, with RSI matching a software sliding-window model on every pulse.
